// File: rtl/sram_rw_arbiter_if.sv
// Bundle of FIFO-head, FIFO-push and SRAM signals between the arbiter (master) and its environment (slave).
interface sram_rw_arbiter_if #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int SRAM_ADDR_WIDTH = 16
);
    localparam int STRB = SRAM_DATA_WIDTH / 8;

    logic [AXI_ADDR_WIDTH-1:0]       aw_fifo_rdata;
    logic                            aw_fifo_empty;
    logic                            aw_fifo_ren;
    logic [SRAM_DATA_WIDTH+STRB-1:0] w_fifo_rdata;
    logic                            w_fifo_empty;
    logic                            w_fifo_ren;
    logic [AXI_ADDR_WIDTH-1:0]       ar_fifo_rdata;
    logic                            ar_fifo_empty;
    logic                            ar_fifo_ren;
    logic [SRAM_DATA_WIDTH-1:0]      r_fifo_wdata;
    logic                            r_fifo_wen;
    logic                            r_fifo_full;
    logic [1:0]                      b_fifo_wdata;
    logic                            b_fifo_wen;
    logic                            b_fifo_full;
    logic                            sram_en;
    logic [STRB-1:0]                 sram_we;
    logic [SRAM_ADDR_WIDTH-1:0]      sram_addr;
    logic [SRAM_DATA_WIDTH-1:0]      sram_din;
    logic [SRAM_DATA_WIDTH-1:0]      sram_dout;
    logic                            busy;

    modport master (
        input  aw_fifo_rdata, aw_fifo_empty, w_fifo_rdata, w_fifo_empty,
        input  ar_fifo_rdata, ar_fifo_empty, r_fifo_full, b_fifo_full, sram_dout,
        output aw_fifo_ren, w_fifo_ren, ar_fifo_ren, r_fifo_wdata, r_fifo_wen,
        output b_fifo_wdata, b_fifo_wen, sram_en, sram_we, sram_addr, sram_din, busy
    );

    modport slave (
        output aw_fifo_rdata, aw_fifo_empty, w_fifo_rdata, w_fifo_empty,
        output ar_fifo_rdata, ar_fifo_empty, r_fifo_full, b_fifo_full, sram_dout,
        input  aw_fifo_ren, w_fifo_ren, ar_fifo_ren, r_fifo_wdata, r_fifo_wen,
        input  b_fifo_wdata, b_fifo_wen, sram_en, sram_we, sram_addr, sram_din, busy
    );
endinterface

// File: rtl/sram_rw_arbiter.sv
// Round-robin write/read scheduler between the CDC FIFOs and a single-port SRAM, one access in flight.
// Optional SRAM_ARB_RANGE_CHECK_EN: out-of-range addresses skip the SRAM and answer SLVERR / zero data.
module sram_rw_arbiter #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int SRAM_ADDR_WIDTH = 16
) (
    input logic               sram_clk,
    input logic               sram_rst_n,
    sram_rw_arbiter_if.master bus
);
    localparam int STRB = SRAM_DATA_WIDTH / 8;

`ifdef SRAM_ARB_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_DATA} state_t;

    state_t                     r_state;
    logic                       r_last_wr;
    logic                       r_rd_err;
    logic                       r_sram_en;
    logic [STRB-1:0]            r_sram_we;
    logic [SRAM_ADDR_WIDTH-1:0] r_sram_addr;
    logic [SRAM_DATA_WIDTH-1:0] r_sram_din;
    logic                       r_aw_ren;
    logic                       r_w_ren;
    logic                       r_ar_ren;
    logic                       r_b_wen;
    logic [1:0]                 r_bresp;
    logic                       r_r_wen;

    logic                       w_wr_pend;
    logic                       w_rd_pend;
    logic                       w_wr_err;
    logic                       w_rd_err;
    logic [SRAM_DATA_WIDTH-1:0] w_wdata;
    logic [STRB-1:0]            w_wstrb;
    logic [SRAM_ADDR_WIDTH-1:0] w_aw_word;
    logic [SRAM_ADDR_WIDTH-1:0] w_ar_word;

    assign w_wr_pend = !bus.aw_fifo_empty && !bus.w_fifo_empty && !bus.b_fifo_full;
    assign w_rd_pend = !bus.ar_fifo_empty && !bus.r_fifo_full;
    assign {w_wdata, w_wstrb} = bus.w_fifo_rdata;
    assign w_aw_word = bus.aw_fifo_rdata[SRAM_ADDR_WIDTH+1:2];
    assign w_ar_word = bus.ar_fifo_rdata[SRAM_ADDR_WIDTH+1:2];
    // Any byte-address bit above the SRAM word range marks the access as out of range.
    assign w_wr_err  = RANGE_CHECK && ((bus.aw_fifo_rdata >> (SRAM_ADDR_WIDTH + 2)) != '0);
    assign w_rd_err  = RANGE_CHECK && ((bus.ar_fifo_rdata >> (SRAM_ADDR_WIDTH + 2)) != '0);

    // Outputs for the next state are registered on the grant edge; FIFO heads are stable until popped.
    always_ff @(posedge sram_clk or negedge sram_rst_n) begin
        if (!sram_rst_n) begin
            r_state     <= IDLE;
            r_last_wr   <= 1'b0;
            r_rd_err    <= 1'b0;
            r_sram_en   <= 1'b0;
            r_sram_we   <= '0;
            r_sram_addr <= '0;
            r_sram_din  <= '0;
            r_aw_ren    <= 1'b0;
            r_w_ren     <= 1'b0;
            r_ar_ren    <= 1'b0;
            r_b_wen     <= 1'b0;
            r_bresp     <= 2'b00;
            r_r_wen     <= 1'b0;
        end else begin
            r_sram_en   <= 1'b0;
            r_sram_we   <= '0;
            r_sram_addr <= '0;
            r_sram_din  <= '0;
            r_aw_ren    <= 1'b0;
            r_w_ren     <= 1'b0;
            r_ar_ren    <= 1'b0;
            r_b_wen     <= 1'b0;
            r_bresp     <= 2'b00;
            r_r_wen     <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_rd_err <= 1'b0;
                    if (w_wr_pend && (!w_rd_pend || !r_last_wr)) begin
                        r_state     <= WR;
                        r_sram_en   <= !w_wr_err;
                        r_sram_we   <= w_wr_err ? '0 : w_wstrb;
                        r_sram_addr <= w_aw_word;
                        r_sram_din  <= w_wdata;
                        r_aw_ren    <= 1'b1;
                        r_w_ren     <= 1'b1;
                        r_b_wen     <= 1'b1;
                        r_bresp     <= w_wr_err ? 2'b10 : 2'b00;
                    end else if (w_rd_pend) begin
                        r_state     <= RD_REQ;
                        r_sram_en   <= !w_rd_err;
                        r_sram_addr <= w_ar_word;
                        r_ar_ren    <= 1'b1;
                        r_rd_err    <= w_rd_err;
                    end
                end
                WR: begin
                    r_state   <= IDLE;
                    r_last_wr <= 1'b1;
                end
                RD_REQ: begin
                    r_state   <= RD_DATA;
                    r_last_wr <= 1'b0;
                    r_r_wen   <= 1'b1;
                end
                RD_DATA: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sram_en      = r_sram_en;
    assign bus.sram_we      = r_sram_we;
    assign bus.sram_addr    = r_sram_addr;
    assign bus.sram_din     = r_sram_din;
    assign bus.aw_fifo_ren  = r_aw_ren;
    assign bus.w_fifo_ren   = r_w_ren;
    assign bus.ar_fifo_ren  = r_ar_ren;
    assign bus.b_fifo_wen   = r_b_wen;
    assign bus.b_fifo_wdata = r_bresp;
    assign bus.r_fifo_wen   = r_r_wen;
    // Read data is the only path taken straight from the SRAM output.
    assign bus.r_fifo_wdata = (r_state == RD_DATA && !r_rd_err) ? bus.sram_dout : '0;
    assign bus.busy         = (r_state != IDLE);
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Scoreboard bench for sram_rw_arbiter: FIFO and SRAM models, a transaction-level predictor and a decoupled monitor.
module tb_sram_rw_arbiter;
    logic clk = 1'b0;
    logic sram_rst_n;
    always #5 clk = ~clk;

    sram_rw_arbiter_if bus ();

    sram_rw_arbiter dut (
        .sram_clk   (clk),
        .sram_rst_n (sram_rst_n),
        .bus        (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wreq_t;

    typedef struct {
        bit          isWr;
        bit          en;
        logic [3:0]  we;
        logic [15:0] addr;
        logic [31:0] din;
    } acc_t;

    int nTests = 0;
    int nFail = 0;
    int cyc = 0;
    int lastArCyc = -10;

    logic [31:0] qAw[$];
    logic [35:0] qW[$];
    logic [31:0] qAr[$];
    wreq_t       pendWr[$];
    logic [31:0] pendRd[$];
    acc_t        expAcc[$];
    logic [1:0]  expB[$];
    logic [31:0] expR[$];
    bit          mLastWr;
    logic [31:0] refMem[int];
    logic [31:0] sramMem[int];
    logic [31:0] sramDout;

    assign bus.sram_dout = sramDout;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit outOfRange(input logic [31:0] a);
`ifdef SRAM_ARB_RANGE_CHECK_EN
        return (a >= 32'h0004_0000);
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic int wordOf(input logic [31:0] a);
        return int'((a >> 2) % 32'h0001_0000);
    endfunction

    always @(posedge clk) cyc++;

    // First-word-fall-through FIFO models: pop on ren at the edge, present new heads just after it.
    initial begin
        forever begin
            bus.aw_fifo_empty = (qAw.size() == 0);
            bus.aw_fifo_rdata = (qAw.size() != 0) ? qAw[0] : 32'h0;
            bus.w_fifo_empty  = (qW.size() == 0);
            bus.w_fifo_rdata  = (qW.size() != 0) ? qW[0] : 36'h0;
            bus.ar_fifo_empty = (qAr.size() == 0);
            bus.ar_fifo_rdata = (qAr.size() != 0) ? qAr[0] : 32'h0;
            @(posedge clk);
            if (!sram_rst_n) begin
                qAw.delete();
                qW.delete();
                qAr.delete();
            end else begin
                if (bus.aw_fifo_ren && qAw.size() != 0) void'(qAw.pop_front());
                if (bus.w_fifo_ren && qW.size() != 0) void'(qW.pop_front());
                if (bus.ar_fifo_ren && qAr.size() != 0) void'(qAr.pop_front());
            end
            #1;
        end
    end

    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we == 4'h0) begin
                sramDout <= sramMem.exists(int'(bus.sram_addr)) ? sramMem[int'(bus.sram_addr)] : 32'h0;
            end else begin
                logic [31:0] cur;
                cur = sramMem.exists(int'(bus.sram_addr)) ? sramMem[int'(bus.sram_addr)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (bus.sram_we[b]) cur[8*b +: 8] = bus.sram_din[8*b +: 8];
                sramMem[int'(bus.sram_addr)] = cur;
            end
        end
    end

    // Monitor: every pop, b push and r push is matched against the next predicted entry.
    always @(negedge clk) begin
        acc_t e;
        if (sram_rst_n) begin
            if (bus.aw_fifo_ren || bus.ar_fifo_ren) begin
                checkOutput("single_pop", {63'h0, bus.aw_fifo_ren & bus.ar_fifo_ren}, 64'h0);
                if (expAcc.size() == 0) begin
                    checkOutput("unexpected_access", 64'h1, 64'h0);
                end else begin
                    e = expAcc.pop_front();
                    checkOutput("grant_is_write", {63'h0, bus.aw_fifo_ren}, {63'h0, e.isWr});
                    checkOutput("sram_en", {63'h0, bus.sram_en}, {63'h0, e.en});
                    checkOutput("sram_we", {60'h0, bus.sram_we}, {60'h0, e.we});
                    checkOutput("sram_addr", {48'h0, bus.sram_addr}, {48'h0, e.addr});
                    if (e.isWr) begin
                        checkOutput("w_pop_with_aw", {63'h0, bus.w_fifo_ren}, 64'h1);
                        checkOutput("b_push_in_wr", {63'h0, bus.b_fifo_wen}, 64'h1);
                        checkOutput("sram_din", {32'h0, bus.sram_din}, {32'h0, e.din});
                    end else begin
                        lastArCyc = cyc;
                    end
                end
            end
            if (bus.b_fifo_wen) begin
                if (expB.size() == 0) checkOutput("unexpected_b_push", 64'h1, 64'h0);
                else checkOutput("bresp", {62'h0, bus.b_fifo_wdata}, {62'h0, expB.pop_front()});
            end
            if (bus.r_fifo_wen) begin
                checkOutput("r_latency", 64'(cyc), 64'(lastArCyc + 1));
                if (expR.size() == 0) checkOutput("unexpected_r_push", 64'h1, 64'h0);
                else checkOutput("rdata", {32'h0, bus.r_fifo_wdata}, {32'h0, expR.pop_front()});
            end
        end
    end

    task automatic addWr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wreq_t w;
        w.addr = a;
        w.data = d;
        w.strb = s;
        pendWr.push_back(w);
    endtask

    task automatic addRd(input logic [31:0] a);
        pendRd.push_back(a);
    endtask

    // Predictor: with all requests present at once, service alternates from the last type served.
    task automatic applyStimulus();
        int wi = 0;
        int ri = 0;
        foreach (pendWr[i]) begin
            qAw.push_back(pendWr[i].addr);
            qW.push_back({pendWr[i].data, pendWr[i].strb});
        end
        foreach (pendRd[i]) qAr.push_back(pendRd[i]);
        while (wi < pendWr.size() || ri < pendRd.size()) begin
            acc_t  e;
            int    word;
            bit    oor;
            logic [31:0] cur;
            if (wi < pendWr.size() && (ri >= pendRd.size() || !mLastWr)) begin
                word = wordOf(pendWr[wi].addr);
                oor  = outOfRange(pendWr[wi].addr);
                e.isWr = 1'b1;
                e.en   = !oor;
                e.we   = oor ? 4'h0 : pendWr[wi].strb;
                e.addr = 16'(word);
                e.din  = pendWr[wi].data;
                expB.push_back(oor ? 2'b10 : 2'b00);
                if (!oor) begin
                    cur = refMem.exists(word) ? refMem[word] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (pendWr[wi].strb[b]) cur[8*b +: 8] = pendWr[wi].data[8*b +: 8];
                    refMem[word] = cur;
                end
                mLastWr = 1'b1;
                wi++;
            end else begin
                word = wordOf(pendRd[ri]);
                oor  = outOfRange(pendRd[ri]);
                e.isWr = 1'b0;
                e.en   = !oor;
                e.we   = 4'h0;
                e.addr = 16'(word);
                e.din  = 32'h0;
                expR.push_back(oor ? 32'h0 : (refMem.exists(word) ? refMem[word] : 32'h0));
                mLastWr = 1'b0;
                ri++;
            end
            expAcc.push_back(e);
        end
        pendWr.delete();
        pendRd.delete();
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((expAcc.size() != 0 || expB.size() != 0 || expR.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_within_budget", {63'h0, n < 300}, 64'h1);
    endtask

    function automatic logic [31:0] randAddr();
        logic [15:0] word;
        logic [13:0] upper;
        word  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 7));
        upper = ($urandom_range(0, 4) == 0) ? 14'($urandom_range(1, 3)) : 14'h0;
        return {upper, word, 2'($urandom)};
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        sram_rst_n = 1'b0;
        bus.r_fifo_full = 1'b0;
        bus.b_fifo_full = 1'b0;
        mLastWr = 1'b0;
        #12;
        checkOutput("rst_busy", {63'h0, bus.busy}, 64'h0);
        checkOutput("rst_sram_en", {63'h0, bus.sram_en}, 64'h0);
        checkOutput("rst_sram_we", {60'h0, bus.sram_we}, 64'h0);
        checkOutput("rst_rens", {61'h0, bus.aw_fifo_ren, bus.w_fifo_ren, bus.ar_fifo_ren}, 64'h0);
        checkOutput("rst_wens", {62'h0, bus.b_fifo_wen, bus.r_fifo_wen}, 64'h0);
        checkOutput("rst_sram_addr", {48'h0, bus.sram_addr}, 64'h0);
        checkOutput("rst_bresp", {62'h0, bus.b_fifo_wdata}, 64'h0);
        checkOutput("rst_rdata", {32'h0, bus.r_fifo_wdata}, 64'h0);
        @(negedge clk);
        sram_rst_n = 1'b1;

        addWr(32'h0000_0010, 32'hCAFE_F00D, 4'hF);
        addRd(32'h0000_0010);
        applyStimulus();
        waitDrain();

        for (int i = 0; i < 2; i++) begin
            addWr(randAddr(), $urandom, 4'($urandom));
            addRd(randAddr());
        end
        applyStimulus();
        waitDrain();

        addWr(32'h0000_0020, 32'hFFFF_FFFF, 4'hF);
        applyStimulus();
        waitDrain();
        addWr(32'h0000_0020, 32'h1122_3344, 4'b0011);
        applyStimulus();
        waitDrain();
        addRd(32'h0000_0020);
        applyStimulus();
        waitDrain();

        addWr(32'h0004_0000, 32'hA5A5_5A5A, 4'hF);
        addRd(32'h0004_0000);
        addRd(32'h0000_0000);
        applyStimulus();
        waitDrain();

        bus.r_fifo_full = 1'b1;
        addRd(32'h0000_0010);
        applyStimulus();
        repeat (6) begin
            @(negedge clk);
            checkOutput("rfull_holds_read", {62'h0, bus.ar_fifo_ren, bus.sram_en}, 64'h0);
        end
        bus.r_fifo_full = 1'b0;
        @(negedge clk);
        checkOutput("rfull_release_grant", {63'h0, bus.ar_fifo_ren}, 64'h1);
        waitDrain();

        bus.b_fifo_full = 1'b1;
        addWr(32'h0000_0030, $urandom, 4'hF);
        applyStimulus();
        repeat (5) begin
            @(negedge clk);
            checkOutput("bfull_holds_write", {62'h0, bus.aw_fifo_ren, bus.sram_en}, 64'h0);
        end
        bus.b_fifo_full = 1'b0;
        @(negedge clk);
        checkOutput("bfull_release_grant", {63'h0, bus.aw_fifo_ren}, 64'h1);
        waitDrain();

        // Reset in RD_REQ right after a write: last_wr must return to 0, so the next pair starts with a write.
        addWr(32'h0000_0040, $urandom, 4'hF);
        applyStimulus();
        waitDrain();
        addRd(32'h0000_0040);
        applyStimulus();
        n = 0;
        while (!bus.ar_fifo_ren && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rd_req_reached", {63'h0, bus.ar_fifo_ren}, 64'h1);
        #1;
        sram_rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_strobes", {59'h0, bus.sram_en, bus.ar_fifo_ren, bus.r_fifo_wen, bus.b_fifo_wen, bus.busy}, 64'h0);
        expR.delete();
        mLastWr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sram_rst_n = 1'b1;
        addWr(32'h0000_0044, $urandom, 4'hF);
        addRd(32'h0000_0044);
        applyStimulus();
        waitDrain();

        for (int t = 0; t < 25; t++) begin
            int nw;
            int nr;
            nw = $urandom_range(0, 4);
            nr = $urandom_range((nw == 0) ? 1 : 0, 4);
            for (int i = 0; i < nw; i++) addWr(randAddr(), $urandom, 4'($urandom));
            for (int i = 0; i < nr; i++) addRd(randAddr());
            applyStimulus();
            waitDrain();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
